// File: rtl/hpm_tracer_pkg.sv
// Shared types and constants for the HPM window tracer: FSM states, CSR trigger values,
// HPM counter indices and the packed snapshot layout carried through the snapshot FIFO.
package hpm_tracer_pkg;

    localparam int HPM_N_CNT = 13;
    localparam int HPM_CNT_W = 64;
    localparam int HPM_DEPTH = 4;
    localparam int SEQ_W     = 16;
    localparam int TAG_W     = 2;

    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [31:0] START_VAL_DEF     = 32'h0000_0000;
    localparam logic [31:0] STOP_VAL_DEF      = 32'hFFFF_FFFF;

    localparam int CYCLE        = 0;
    localparam int INSTR        = 2;
    localparam int LD_STALL     = 3;
    localparam int JMP_STALL    = 4;
    localparam int IMISS        = 5;
    localparam int LD           = 6;
    localparam int ST           = 7;
    localparam int JUMP         = 8;
    localparam int BRANCH       = 9;
    localparam int BRANCH_TAKEN = 10;
    localparam int COMP_INSTR   = 11;

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_e;

    typedef struct packed {
        logic [HPM_N_CNT-1:0][HPM_CNT_W-1:0] delta;
        logic [TAG_W-1:0]                    target;
        logic [SEQ_W-1:0]                    seq;
    } snap_t;

endpackage

// File: rtl/hpm_snap_fifo.sv
// Snapshot FIFO, first-word fall-through; head valid one cycle after the first write.
// pop_vld_o is registered; a push on full is accepted only when a pop happens the same cycle.
module hpm_snap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_h,
    input  logic             rst_h,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    output logic             push_rdy_o,
    output logic             pop_vld_o,
    output logic [WIDTH-1:0] pop_dat_o,
    input  logic             pop_rdy_i
);

    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]                 cnt_q, cnt_d;
    logic                        empty, full, push, pop;

    assign empty      = (cnt_q == '0);
    assign full       = (cnt_q == (AW+1)'(DEPTH));
    assign pop        = pop_rdy_i & ~empty;
    // When full, the slot being popped is the one the push overwrites.
    assign push_rdy_o = ~full | pop_rdy_i;
    assign push       = push_vld_i & push_rdy_o;

    assign pop_vld_o  = ~empty;
    assign pop_dat_o  = empty ? '0 : mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = push_dat_i;
            wr_d        = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            mem_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hpm_window_tracer.sv
// CSR-triggered HPM window tracer: start/stop writes bracket a window, stop queues per-counter deltas.
// Snapshot valid one cycle after stop into an empty queue; full queue with no pop drops and counts.
module hpm_window_tracer
    import hpm_tracer_pkg::*;
#(
    parameter int          N_CNT     = HPM_N_CNT,
    parameter int          CNT_W     = HPM_CNT_W,
    parameter int          DEPTH     = HPM_DEPTH,
    parameter logic [11:0] CSR_ADDR  = CSR_MCOUNTINHIBIT,
    parameter logic [31:0] START_VAL = START_VAL_DEF,
    parameter logic [31:0] STOP_VAL  = STOP_VAL_DEF
) (
    input  logic                        clk_h,
    input  logic                        rst_h,
    input  logic                        csr_we_i,
    input  logic [11:0]                 csr_add_i,
    input  logic [31:0]                 csr_data_i,
    input  logic [N_CNT-1:0][CNT_W-1:0] hpm_i,
    input  logic [1:0]                  target_i,
    output logic                        smp_valid_o,
    input  logic                        smp_ready_i,
    output logic [N_CNT-1:0][CNT_W-1:0] smp_delta_o,
    output logic [1:0]                  smp_target_o,
    output logic [15:0]                 smp_seq_o,
    output logic                        busy_o,
    output logic                        ovf_o,
    input  logic                        ovf_clr_i,
    output logic [15:0]                 drop_cnt_o
);

    state_e                      state_q, state_d;
    logic [N_CNT-1:0][CNT_W-1:0] base_q, base_d;
    logic [1:0]                  tag_q, tag_d;
    logic [15:0]                 seq_q, seq_d;
    logic                        ovf_q, ovf_d;
    logic [15:0]                 drop_cnt_q, drop_cnt_d;

    logic  start_evt, stop_evt;
    logic  push_vld, push_rdy, drop;
    snap_t push_dat, head_dat;

    assign start_evt = csr_we_i & (csr_add_i == CSR_ADDR) & (csr_data_i == START_VAL);
    assign stop_evt  = csr_we_i & (csr_add_i == CSR_ADDR) & (csr_data_i == STOP_VAL);

    // Modular subtraction gives the right unsigned delta across a counter wrap.
    always_comb begin
        push_dat = '0;
        for (int k = 0; k < N_CNT; k++) begin
            push_dat.delta[k] = hpm_i[k] - base_q[k];
        end
        push_dat.target = tag_q;
        push_dat.seq    = seq_q;
    end

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        tag_d    = tag_q;
        seq_d    = seq_q;
        push_vld = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_evt) begin
                    state_d = MEAS;
                    base_d  = hpm_i;
                    tag_d   = target_i;
                end
            end
            MEAS: begin
                if (start_evt) begin
                    base_d = hpm_i;
                    tag_d  = target_i;
                end else if (stop_evt) begin
                    state_d  = IDLE;
                    push_vld = 1'b1;
                    seq_d    = seq_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign drop       = push_vld & ~push_rdy;
    assign ovf_d      = drop | (ovf_q & ~ovf_clr_i);
    assign drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            state_q    <= IDLE;
            base_q     <= '0;
            tag_q      <= '0;
            seq_q      <= '0;
            ovf_q      <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            tag_q      <= tag_d;
            seq_q      <= seq_d;
            ovf_q      <= ovf_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    hpm_snap_fifo #(
        .WIDTH ($bits(snap_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_h      (clk_h),
        .rst_h      (rst_h),
        .push_vld_i (push_vld),
        .push_dat_i (push_dat),
        .push_rdy_o (push_rdy),
        .pop_vld_o  (smp_valid_o),
        .pop_dat_o  (head_dat),
        .pop_rdy_i  (smp_ready_i)
    );

    assign smp_delta_o  = head_dat.delta;
    assign smp_target_o = head_dat.target;
    assign smp_seq_o    = head_dat.seq;
    assign busy_o       = (state_q == MEAS);
    assign ovf_o        = ovf_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_hpm_window_tracer.sv
// Directed bench for hpm_window_tracer: drives on the falling edge, checks just before driving.
module tb_hpm_window_tracer;

    localparam int N = 13;
    localparam int W = 64;
    localparam logic [31:0] START = 32'h0000_0000;
    localparam logic [31:0] STOP  = 32'hFFFF_FFFF;

    logic               clk_h = 1'b0;
    logic               rst_h;
    logic               csr_we_i;
    logic [11:0]        csr_add_i;
    logic [31:0]        csr_data_i;
    logic [N-1:0][W-1:0] hpm_i;
    logic [1:0]         target_i;
    logic               smp_valid_o;
    logic               smp_ready_i;
    logic [N-1:0][W-1:0] smp_delta_o;
    logic [1:0]         smp_target_o;
    logic [15:0]        smp_seq_o;
    logic               busy_o;
    logic               ovf_o;
    logic               ovf_clr_i;
    logic [15:0]        drop_cnt_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_h = ~clk_h;

    hpm_window_tracer dut (
        .clk_h        (clk_h),
        .rst_h        (rst_h),
        .csr_we_i     (csr_we_i),
        .csr_add_i    (csr_add_i),
        .csr_data_i   (csr_data_i),
        .hpm_i        (hpm_i),
        .target_i     (target_i),
        .smp_valid_o  (smp_valid_o),
        .smp_ready_i  (smp_ready_i),
        .smp_delta_o  (smp_delta_o),
        .smp_target_o (smp_target_o),
        .smp_seq_o    (smp_seq_o),
        .busy_o       (busy_o),
        .ovf_o        (ovf_o),
        .ovf_clr_i    (ovf_clr_i),
        .drop_cnt_o   (drop_cnt_o)
    );

    // Called at a falling edge; the write is sampled by the next rising edge.
    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input logic clr);
        csr_we_i   = 1'b1;
        csr_add_i  = a;
        csr_data_i = d;
        ovf_clr_i  = clr;
        @(negedge clk_h);
        csr_we_i   = 1'b0;
        ovf_clr_i  = 1'b0;
    endtask

    task automatic window(input logic [W-1:0] b, input logic [W-1:0] e, input logic [1:0] t,
                          input logic clr);
        hpm_i[0] = b;
        target_i = t;
        csr_wr(12'h320, START, 1'b0);
        hpm_i[0] = e;
        csr_wr(12'h320, STOP, clr);
    endtask

    task automatic pop_one();
        smp_ready_i = 1'b1;
        @(negedge clk_h);
        smp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_h = 1'b0; csr_we_i = 1'b0; csr_add_i = '0; csr_data_i = '0;
        hpm_i = '0; target_i = '0; smp_ready_i = 1'b0; ovf_clr_i = 1'b0;
        repeat (2) @(negedge clk_h);
        checks++; if (smp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", smp_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b exp 0", busy_o); end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0b exp 0", ovf_o); end
        checks++; if (drop_cnt_o !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d exp 0", drop_cnt_o); end
        checks++; if (smp_seq_o !== 16'd0) begin errors++; $display("FAIL rst_seq got %0d exp 0", smp_seq_o); end
        checks++; if (smp_delta_o !== '0 || smp_target_o !== 2'd0) begin errors++; $display("FAIL rst_data got delta0 %0h tgt %0d exp 0", smp_delta_o[0], smp_target_o); end
        rst_h = 1'b1;
        @(negedge clk_h);
    endtask

    task automatic test_basic();
        smp_ready_i = 1'b1;
        hpm_i[0] = 64'd100;
        target_i = 2'd2;
        csr_wr(12'h320, START, 1'b0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL basic_busy got %0b exp 1", busy_o); end
        target_i = 2'd1;
        hpm_i[0] = 64'd350;
        csr_wr(12'h320, STOP, 1'b0);
        checks++; if (smp_valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", smp_valid_o); end
        checks++; if (smp_delta_o[0] !== 64'd250) begin errors++; $display("FAIL basic_delta0 got %0d exp 250", smp_delta_o[0]); end
        checks++; if (smp_delta_o[1] !== 64'd0) begin errors++; $display("FAIL basic_delta1 got %0d exp 0", smp_delta_o[1]); end
        checks++; if (smp_seq_o !== 16'd0) begin errors++; $display("FAIL basic_seq got %0d exp 0", smp_seq_o); end
        checks++; if (smp_target_o !== 2'd2) begin errors++; $display("FAIL basic_target got %0d exp 2", smp_target_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %0b exp 0", busy_o); end
        @(negedge clk_h);
        smp_ready_i = 1'b0;
        checks++; if (smp_valid_o !== 1'b0) begin errors++; $display("FAIL basic_popped got %0b exp 0", smp_valid_o); end
    endtask

    task automatic test_wrap();
        hpm_i[2] = 64'hFFFF_FFFF_FFFF_FFF0;
        target_i = 2'd0;
        csr_wr(12'h320, START, 1'b0);
        hpm_i[2] = 64'h10;
        csr_wr(12'h320, STOP, 1'b0);
        checks++; if (smp_delta_o[2] !== 64'h20) begin errors++; $display("FAIL wrap_delta2 got %0h exp 20", smp_delta_o[2]); end
        checks++; if (smp_seq_o !== 16'd1) begin errors++; $display("FAIL wrap_seq got %0d exp 1", smp_seq_o); end
        pop_one();
    endtask

    task automatic test_restart();
        csr_wr(12'h320, STOP, 1'b0);
        checks++; if (smp_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL idle_stop got vld %0b busy %0b exp 0 0", smp_valid_o, busy_o); end
        hpm_i[0] = 64'd100;
        target_i = 2'd1;
        csr_wr(12'h320, START, 1'b0);
        repeat (4) @(negedge clk_h);
        hpm_i[0] = 64'd500;
        target_i = 2'd3;
        csr_wr(12'h320, START, 1'b0);
        csr_wr(12'h321, STOP, 1'b0);
        csr_wr(12'h320, 32'h1234_5678, 1'b0);
        checks++; if (busy_o !== 1'b1 || smp_valid_o !== 1'b0) begin errors++; $display("FAIL other_write got busy %0b vld %0b exp 1 0", busy_o, smp_valid_o); end
        hpm_i[0] = 64'd520;
        csr_wr(12'h320, STOP, 1'b0);
        checks++; if (smp_delta_o[0] !== 64'd20) begin errors++; $display("FAIL restart_delta got %0d exp 20", smp_delta_o[0]); end
        checks++; if (smp_target_o !== 2'd3) begin errors++; $display("FAIL restart_target got %0d exp 3", smp_target_o); end
        checks++; if (smp_seq_o !== 16'd2) begin errors++; $display("FAIL restart_seq got %0d exp 2", smp_seq_o); end
        pop_one();
        checks++; if (smp_valid_o !== 1'b0) begin errors++; $display("FAIL restart_one_entry got %0b exp 0", smp_valid_o); end
    endtask

    task automatic test_overflow();
        rst_h = 1'b0;
        @(negedge clk_h);
        rst_h = 1'b1;
        hpm_i = '0;
        smp_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) window(64'd0, 64'(10 * (i + 1)), 2'd1, 1'b0);
        checks++; if (ovf_o !== 1'b1 || drop_cnt_o !== 16'd1) begin errors++; $display("FAIL ovf_first got ovf %0b drop %0d exp 1 1", ovf_o, drop_cnt_o); end
        window(64'd0, 64'd60, 2'd1, 1'b1);
        checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_clr_vs_drop got %0b exp 1", ovf_o); end
        checks++; if (drop_cnt_o !== 16'd2) begin errors++; $display("FAIL ovf_drop_cnt got %0d exp 2", drop_cnt_o); end
        ovf_clr_i = 1'b1;
        @(negedge clk_h);
        ovf_clr_i = 1'b0;
        checks++; if (ovf_o !== 1'b0 || drop_cnt_o !== 16'd2) begin errors++; $display("FAIL ovf_clr got ovf %0b drop %0d exp 0 2", ovf_o, drop_cnt_o); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (smp_valid_o !== 1'b1 || smp_seq_o !== 16'(i) || smp_delta_o[0] !== 64'(10 * (i + 1)))
                begin errors++; $display("FAIL drain_%0d got vld %0b seq %0d delta %0d exp 1 %0d %0d", i, smp_valid_o, smp_seq_o, smp_delta_o[0], i, 10 * (i + 1)); end
            pop_one();
        end
        checks++; if (smp_valid_o !== 1'b0) begin errors++; $display("FAIL drain_empty got %0b exp 0", smp_valid_o); end
        window(64'd0, 64'd77, 2'd2, 1'b0);
        checks++; if (smp_seq_o !== 16'd6 || smp_delta_o[0] !== 64'd77) begin errors++; $display("FAIL next_seq got seq %0d delta %0d exp 6 77", smp_seq_o, smp_delta_o[0]); end
        pop_one();
    endtask

    task automatic test_full_pop();
        smp_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) window(64'd0, 64'(i + 1), 2'd0, 1'b0);
        hpm_i[0] = 64'd0;
        csr_wr(12'h320, START, 1'b0);
        hpm_i[0] = 64'd99;
        smp_ready_i = 1'b1;
        csr_wr(12'h320, STOP, 1'b0);
        smp_ready_i = 1'b0;
        checks++; if (ovf_o !== 1'b0 || drop_cnt_o !== 16'd2) begin errors++; $display("FAIL fullpop_nodrop got ovf %0b drop %0d exp 0 2", ovf_o, drop_cnt_o); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (smp_valid_o !== 1'b1 || smp_seq_o !== 16'(8 + i)) begin errors++; $display("FAIL fullpop_seq_%0d got vld %0b seq %0d exp 1 %0d", i, smp_valid_o, smp_seq_o, 8 + i); end
            if (i == 3) begin
                checks++; if (smp_delta_o[0] !== 64'd99) begin errors++; $display("FAIL fullpop_last got %0d exp 99", smp_delta_o[0]); end
            end
            pop_one();
        end
        checks++; if (smp_valid_o !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %0b exp 0", smp_valid_o); end
    endtask

    task automatic test_backpressure_reset();
        smp_ready_i = 1'b0;
        window(64'd0, 64'd5, 2'd1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            hpm_i[0] = 64'(3 * i + 1000);
            checks++; if (smp_valid_o !== 1'b1 || smp_seq_o !== 16'd12 || smp_delta_o[0] !== 64'd5 || smp_target_o !== 2'd1)
                begin errors++; $display("FAIL hold_%0d got vld %0b seq %0d delta %0d tgt %0d exp 1 12 5 1", i, smp_valid_o, smp_seq_o, smp_delta_o[0], smp_target_o); end
            @(negedge clk_h);
        end
        window(64'd0, 64'd6, 2'd2, 1'b0);
        csr_wr(12'h320, START, 1'b0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL pre_rst_busy got %0b exp 1", busy_o); end
        #2 rst_h = 1'b0;
        #1;
        checks++; if (smp_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL midrst got vld %0b busy %0b exp 0 0", smp_valid_o, busy_o); end
        checks++; if (drop_cnt_o !== 16'd0 || ovf_o !== 1'b0 || smp_seq_o !== 16'd0) begin errors++; $display("FAIL midrst_cnt got drop %0d ovf %0b seq %0d exp 0 0 0", drop_cnt_o, ovf_o, smp_seq_o); end
        checks++; if (smp_delta_o !== '0 || smp_target_o !== 2'd0) begin errors++; $display("FAIL midrst_data got delta0 %0d tgt %0d exp 0 0", smp_delta_o[0], smp_target_o); end
        @(negedge clk_h);
        rst_h = 1'b1;
        @(negedge clk_h);
        checks++; if (smp_valid_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL post_rst got vld %0b busy %0b exp 0 0", smp_valid_o, busy_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_restart();
        test_overflow();
        test_full_pop();
        test_backpressure_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
